wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Round-robin bus arbiter that shares one Wishbone master port of the intercon between up to `MASTERS_NUM` bus masters (CPU plus future DMA/debug masters). It sits between the masters and the intercon's `m2i_*`/`i2m_*` side, so the intercon continues to see exactly one master. It holds a grant for a whole `cyc` cycle and rotates priority on release. A bus watchdog terminates slave accesses that never acknowledge.

## Interface
Parameters:
- `MASTERS_NUM`, 2: number of masters, 2..8.
- `TIMEOUT`, 255: cycles a strobed access may wait for ack/err before the block forces err; 0 disables the watchdog.
- `ADR_WIDTH`/`DAT_WIDTH`/`SEL_WIDTH`, `` `ADR_WIDTH``/`` `DAT_WIDTH``/`` `SEL_WIDTH``: bus widths.

Ports (N = `MASTERS_NUM`; vectors are packed with master 0 in the LSBs):
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-low reset.
- `m_cyc_i`, `m_stb_i`, `m_we_i` in N each: per-master cycle, strobe and write-enable.
- `m_adr_i` in N*ADR_WIDTH, `m_dat_i` in N*DAT_WIDTH, `m_sel_i` in N*SEL_WIDTH: per-master address, write data and byte selects.
- `m_ack_o`, `m_err_o` out N each: per-master termination.
- `m_dat_o` out DAT_WIDTH: read data, shared by all masters.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each; `s_adr_o`, `s_dat_o`, `s_sel_o` out width-matched: toward the intercon.
- `s_ack_i`, `s_err_i` in 1 each; `s_dat_i` in DAT_WIDTH: from the intercon.
- `gnt_o` out N: one-hot current grant, all zero when idle.

## Operation
State machine:
- IDLE: all `s_*` outputs are 0.
  - If any `m_cyc_i` bit is set, select the first requester at or after `ptr` (wrapping modulo N) and register it as `gnt`.
  - Move to BUSY.
- BUSY: the `s_*` outputs are a combinational mux of master `gnt`.
  - `s_cyc_o = m_cyc_i[gnt]`.
  - `s_stb_o = m_cyc_i[gnt] & m_stb_i[gnt]`.
  - `m_ack_o[gnt] = s_ack_i & s_stb_o`; `m_err_o[gnt] = (s_err_i | wd_err) & s_stb_o`.
  - Non-granted masters see ack = 0 and err = 0. `m_dat_o = s_dat_i` unconditionally.
- Release: a cycle in BUSY with `m_cyc_i[gnt] = 0`.
  - `s_cyc_o` is already 0 in that cycle.
  - Next state is IDLE, `ptr <= (gnt+1) mod N`, and `gnt` is cleared.
- Bus lock: a master keeps the grant for as long as it holds `cyc`, across any number of strobes. No preemption.

Watchdog, active only when `TIMEOUT` > 0:
- Counter `wd_cnt` has width `$clog2(TIMEOUT+1)`.
- In BUSY with `s_stb_o = 1` and no `s_ack_i`/`s_err_i`, it increments.
- In any other case it clears.
- `wd_err` is asserted combinationally when `wd_cnt == TIMEOUT`, and the counter clears on the next edge.
- If `s_ack_i` and the timeout occur in the same cycle, ack wins: `wd_err` is suppressed and only ack is issued.

Boundaries:
- Simultaneous requests are resolved by `ptr` order.
- A single requester is granted regardless of `ptr`.
- A requester that drops `cyc` while not granted is simply skipped.
- `ptr` wraps from N-1 to 0.
- Reset (`rst_i` = 0 sampled at an edge), including mid-transfer: after that edge the state is IDLE, `ptr = 0`, `gnt = 0` and `wd_cnt = 0`, so every `s_*`, `m_ack_o`, `m_err_o` and `gnt_o` reads 0. The aborted slave access is not completed.

## Timing
- Arbitration latency: a master raising `cyc` in cycle 0 while the block is in IDLE sees `s_cyc_o` high in cycle 1.
- Turnaround: release in cycle k gives IDLE in k+1 and a new grant's `s_cyc_o` in k+2. There is one guaranteed dead cycle between owners.
- Data/ack path: zero added latency once granted; purely combinational through the mux.
- Watchdog: an unanswered strobe in cycles 1..T+1 yields `m_err_o` in cycle T+1, where T = `TIMEOUT`.
- Reset values: all outputs 0, state IDLE.

## Structure
- Bus widths come from the shared `config.v` defines; the Wishbone port macros stay in `wishbone.v`.
- State encodings (`ST_IDLE`, `ST_BUSY`) are local parameters.
- Sub-module `wb_rr_picker`: combinational round-robin priority encoder.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot grant and valid.
  - Reusable for future interrupt arbitration.

## Test plan
- Single master: M0 performs a read at 0x100, slave acks after 2 cycles → `s_cyc_o` high 1 cycle after `m_cyc_i[0]`; `m_ack_o[0]` pulses; `m_dat_o` equals `s_dat_i`; `gnt_o = 01`.
- Contention, N=3, `ptr = 0`: all masters raise `cyc` together → grants M0, M1, M2 in order, each separated by exactly one IDLE cycle; `gnt_o = 001`, `010`, `100`.
- Bus lock: M1 holds `cyc` over 4 strobes while M0 requests → M0 is never acked until M1 releases; M0 is granted 2 cycles after the release.
- Watchdog, `TIMEOUT = 4`: the slave never acks → `m_err_o` of the granted master pulses after exactly 5 strobed cycles; ack coinciding with the timeout produces ack only, err = 0.
- Reset mid-access: assert `rst_i` = 0 during M2's strobe → the next cycle shows all outputs 0; after release, M0 wins arbitration first because `ptr = 0`.
- Wrap-around: M2 releases (`ptr` → 0) with M0 and M2 requesting → M0 is granted.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_pkg
// Brief    : Shared bus widths and sizing helpers for the Wishbone arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int WB_ADR_WIDTH = 32;
    localparam int WB_DAT_WIDTH = 32;
    localparam int WB_SEL_WIDTH = 4;

    // Width of a master index; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Watchdog counter width; a disabled watchdog still needs a legal vector.
    function automatic int wd_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_picker
// Brief    : Combinational round-robin priority encoder (first request at or
//            after the pointer, wrapping).
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_picker
    import wb_arbiter_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int PTR_W = ptr_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [WIDTH-1:0] o_gnt,
    output logic             o_valid
);

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_hi;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask[i] = (i >= int'(i_ptr));
        end
    end

    // Lowest set bit among requests at/above the pointer, else wrap to the lowest overall.
    assign w_hi    = i_req & w_mask;
    assign o_gnt   = (|w_hi) ? (w_hi & (~w_hi + WIDTH'(1)))
                             : (i_req & (~i_req + WIDTH'(1)));
    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Round-robin Wishbone arbiter with cycle-long bus lock and a
//            watchdog that errors out unanswered strobes.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int MASTERS_NUM = 2,
    parameter int TIMEOUT     = 255,
    parameter int ADR_WIDTH   = WB_ADR_WIDTH,
    parameter int DAT_WIDTH   = WB_DAT_WIDTH,
    parameter int SEL_WIDTH   = WB_SEL_WIDTH
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [MASTERS_NUM-1:0]           m_cyc_i,
    input  logic [MASTERS_NUM-1:0]           m_stb_i,
    input  logic [MASTERS_NUM-1:0]           m_we_i,
    input  logic [MASTERS_NUM*ADR_WIDTH-1:0] m_adr_i,
    input  logic [MASTERS_NUM*DAT_WIDTH-1:0] m_dat_i,
    input  logic [MASTERS_NUM*SEL_WIDTH-1:0] m_sel_i,
    output logic [MASTERS_NUM-1:0]           m_ack_o,
    output logic [MASTERS_NUM-1:0]           m_err_o,
    output logic [DAT_WIDTH-1:0]             m_dat_o,
    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [ADR_WIDTH-1:0]             s_adr_o,
    output logic [DAT_WIDTH-1:0]             s_dat_o,
    output logic [SEL_WIDTH-1:0]             s_sel_o,
    input  logic                             s_ack_i,
    input  logic                             s_err_i,
    input  logic [DAT_WIDTH-1:0]             s_dat_i,
    output logic [MASTERS_NUM-1:0]           gnt_o
);

    localparam int         PTR_W   = ptr_width(MASTERS_NUM);
    localparam int         WD_W    = wd_width(TIMEOUT);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [MASTERS_NUM-1:0] r_gnt;
    logic [MASTERS_NUM-1:0] w_gnt_nxt;
    logic [MASTERS_NUM-1:0] w_pick_gnt;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       w_ptr_nxt;
    logic [PTR_W-1:0]       w_gnt_idx;
    logic                   w_pick_vld;
    logic                   w_own_cyc;
    logic                   w_wd_err;

    wb_rr_picker #(
        .WIDTH (MASTERS_NUM),
        .PTR_W (PTR_W)
    ) u_picker (
        .i_req   (m_cyc_i),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_valid (w_pick_vld)
    );

    assign w_own_cyc = |(m_cyc_i & r_gnt);

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < MASTERS_NUM; i++) begin
            if (r_gnt[i]) w_gnt_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_BUSY;
                    w_gnt_nxt   = w_pick_gnt;
                end
            end
            ST_BUSY: begin
                // The owner dropping cyc ends the lock; priority moves past it.
                if (!w_own_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = (w_gnt_idx == PTR_W'(MASTERS_NUM - 1)) ? '0
                                                                         : w_gnt_idx + PTR_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_gnt is all-zero in IDLE, so the AND-OR mux also zeroes the slave side there.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        for (int i = 0; i < MASTERS_NUM; i++) begin
            if (r_gnt[i]) begin
                s_adr_o = m_adr_i[i*ADR_WIDTH +: ADR_WIDTH];
                s_dat_o = m_dat_i[i*DAT_WIDTH +: DAT_WIDTH];
                s_sel_o = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
                s_we_o  = m_we_i[i];
            end
        end
        s_cyc_o = w_own_cyc;
        s_stb_o = |(m_cyc_i & m_stb_i & r_gnt);
        m_ack_o = r_gnt & {MASTERS_NUM{s_ack_i & s_stb_o}};
        m_err_o = r_gnt & {MASTERS_NUM{(s_err_i | w_wd_err) & s_stb_o}};
        m_dat_o = s_dat_i;
        gnt_o   = r_gnt;
    end

    generate
        if (TIMEOUT > 0) begin : g_wd
            logic [WD_W-1:0] r_wd_cnt;
            logic            w_wd_hit;

            assign w_wd_hit = (r_wd_cnt == WD_W'(TIMEOUT));
            // A coinciding ack wins over the timeout.
            assign w_wd_err = w_wd_hit & ~s_ack_i;

            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    r_wd_cnt <= '0;
                end else if ((r_state == ST_BUSY) && s_stb_o && !s_ack_i && !s_err_i && !w_wd_hit) begin
                    r_wd_cnt <= r_wd_cnt + WD_W'(1);
                end else begin
                    r_wd_cnt <= '0;
                end
            end
        end else begin : g_no_wd
            assign w_wd_err = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Self-checking bench for wb_arbiter (3 masters, watchdog of 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int N  = 3;
    localparam int T  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*SW-1:0] m_sel_i;
    logic [N-1:0]    m_ack_o, m_err_o;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic            s_ack_i, s_err_i;
    logic [DW-1:0]   s_dat_i;
    logic [N-1:0]    gnt_o;

    always #5 clk = ~clk;

    wb_arbiter #(
        .MASTERS_NUM (N),
        .TIMEOUT     (T),
        .ADR_WIDTH   (AW),
        .DAT_WIDTH   (DW),
        .SEL_WIDTH   (SW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_dat_i (s_dat_i),
        .gnt_o   (gnt_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = nobody), rotating pointer, wait count.
    int own   = -1;
    int ptr   = 0;
    int wcnt  = 0;
    bit known = 1'b0;

    task automatic mdl_check();
        logic [N-1:0]  e_gnt  = '0;
        logic [N-1:0]  e_ack  = '0;
        logic [N-1:0]  e_err  = '0;
        logic          e_cyc  = 1'b0;
        logic          e_stb  = 1'b0;
        logic          e_we   = 1'b0;
        logic [AW-1:0] e_adr  = '0;
        logic [DW-1:0] e_dat  = '0;
        logic [SW-1:0] e_sel  = '0;
        logic          timeout;
        if (own >= 0) begin
            e_gnt[own] = 1'b1;
            e_cyc      = m_cyc_i[own];
            e_stb      = m_cyc_i[own] & m_stb_i[own];
            e_we       = m_we_i[own];
            e_adr      = m_adr_i[own*AW +: AW];
            e_dat      = m_dat_i[own*DW +: DW];
            e_sel      = m_sel_i[own*SW +: SW];
            timeout    = (wcnt == T) && !s_ack_i;
            e_ack[own] = s_ack_i & e_stb;
            e_err[own] = (s_err_i | timeout) & e_stb;
        end
        chk("mdl_gnt",   32'(gnt_o),   32'(e_gnt));
        chk("mdl_s_cyc", 32'(s_cyc_o), 32'(e_cyc));
        chk("mdl_s_stb", 32'(s_stb_o), 32'(e_stb));
        chk("mdl_s_we",  32'(s_we_o),  32'(e_we));
        chk("mdl_s_adr", 32'(s_adr_o), 32'(e_adr));
        chk("mdl_s_dat", 32'(s_dat_o), 32'(e_dat));
        chk("mdl_s_sel", 32'(s_sel_o), 32'(e_sel));
        chk("mdl_ack",   32'(m_ack_o), 32'(e_ack));
        chk("mdl_err",   32'(m_err_o), 32'(e_err));
        chk("mdl_m_dat", 32'(m_dat_o), 32'(s_dat_i));
    endtask

    task automatic mdl_update();
        if (!rst_i) begin
            own = -1; ptr = 0; wcnt = 0; known = 1'b1;
        end else if (own < 0) begin
            wcnt = 0;
            for (int k = 0; k < N; k++) begin
                if (m_cyc_i[(ptr + k) % N]) begin
                    own = (ptr + k) % N;
                    break;
                end
            end
        end else if (!m_cyc_i[own]) begin
            ptr = (own + 1) % N; own = -1; wcnt = 0;
        end else if (m_stb_i[own] && !s_ack_i && !s_err_i && wcnt < T) begin
            wcnt++;
        end else begin
            wcnt = 0;
        end
    endtask

    logic [N-1:0] cap_gnt, cap_ack, cap_err;
    logic         cap_cyc;

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the falling edge.
    task automatic tick(input logic rstn, input logic [N-1:0] cyc, input logic [N-1:0] stb,
                        input logic sack, input logic serr);
        rst_i   = rstn;
        m_cyc_i = cyc;
        m_stb_i = stb;
        s_ack_i = sack;
        s_err_i = serr;
        m_we_i  = N'($urandom);
        for (int m = 0; m < N; m++) begin
            m_adr_i[m*AW +: AW] = AW'($urandom);
            m_dat_i[m*DW +: DW] = DW'($urandom);
            m_sel_i[m*SW +: SW] = SW'($urandom);
        end
        s_dat_i = DW'($urandom);
        @(negedge clk);
        if (known) mdl_check();
        cap_gnt = gnt_o;
        cap_cyc = s_cyc_o;
        cap_ack = m_ack_o;
        cap_err = m_err_o;
        @(posedge clk);
        mdl_update();
        #1;
    endtask

    typedef struct {
        logic         rstn;
        logic [N-1:0] cyc;
        logic [N-1:0] stb;
        logic         sack;
        logic         en;
        logic [N-1:0] gnt;
        logic         scyc;
        logic [N-1:0] ack;
        logic [N-1:0] err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int rep, input logic rstn, input logic [N-1:0] cyc, input logic [N-1:0] stb,
                       input logic sack, input logic en, input logic [N-1:0] gnt, input logic scyc,
                       input logic [N-1:0] ack, input logic [N-1:0] err);
        vec_t v;
        v = '{rstn, cyc, stb, sack, en, gnt, scyc, ack, err};
        repeat (rep) tbl.push_back(v);
    endtask

    initial begin
        // reset, then single-master read with ack after two waits
        add(1, 0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 3'b000, 3'b000);
        add(1, 1, 3'b000, 3'b000, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        add(1, 1, 3'b001, 3'b001, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        add(2, 1, 3'b001, 3'b001, 0, 1, 3'b001, 1, 3'b000, 3'b000);
        add(1, 1, 3'b001, 3'b001, 1, 1, 3'b001, 1, 3'b001, 3'b000);
        add(1, 1, 3'b000, 3'b000, 0, 1, 3'b001, 0, 3'b000, 3'b000);
        add(1, 1, 3'b000, 3'b000, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        // contention from ptr = 0
        add(1, 0, 3'b111, 3'b000, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        add(1, 1, 3'b111, 3'b000, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        add(1, 1, 3'b111, 3'b111, 1, 1, 3'b001, 1, 3'b001, 3'b000);
        add(1, 1, 3'b110, 3'b110, 0, 1, 3'b001, 0, 3'b000, 3'b000);
        add(1, 1, 3'b110, 3'b110, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        add(1, 1, 3'b110, 3'b110, 1, 1, 3'b010, 1, 3'b010, 3'b000);
        add(1, 1, 3'b100, 3'b100, 0, 1, 3'b010, 0, 3'b000, 3'b000);
        add(1, 1, 3'b100, 3'b100, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        add(1, 1, 3'b100, 3'b100, 1, 1, 3'b100, 1, 3'b100, 3'b000);
        // wrap-around: M2 releases, M0 and M2 request, M0 wins
        add(1, 1, 3'b001, 3'b000, 0, 1, 3'b100, 0, 3'b000, 3'b000);
        add(1, 1, 3'b101, 3'b000, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        add(1, 1, 3'b101, 3'b001, 0, 1, 3'b001, 1, 3'b000, 3'b000);
        // bus lock: M1 holds cyc over 4 strobes while M0 waits; M2 drops and is skipped
        add(1, 1, 3'b110, 3'b000, 0, 1, 3'b001, 0, 3'b000, 3'b000);
        add(1, 1, 3'b010, 3'b000, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        add(4, 1, 3'b011, 3'b010, 1, 1, 3'b010, 1, 3'b010, 3'b000);
        add(1, 1, 3'b001, 3'b001, 1, 1, 3'b010, 0, 3'b000, 3'b000);
        add(1, 1, 3'b001, 3'b001, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        // watchdog: err on the 5th unanswered strobe, then ack beating the timeout
        add(4, 1, 3'b001, 3'b001, 0, 1, 3'b001, 1, 3'b000, 3'b000);
        add(1, 1, 3'b001, 3'b001, 0, 1, 3'b001, 1, 3'b000, 3'b001);
        add(4, 1, 3'b001, 3'b001, 0, 1, 3'b001, 1, 3'b000, 3'b000);
        add(1, 1, 3'b001, 3'b001, 1, 1, 3'b001, 1, 3'b001, 3'b000);
        // reset during M2's strobe, then M0 wins from ptr = 0
        add(1, 1, 3'b100, 3'b100, 0, 1, 3'b001, 0, 3'b000, 3'b000);
        add(1, 1, 3'b100, 3'b100, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        add(1, 1, 3'b101, 3'b100, 0, 1, 3'b100, 1, 3'b000, 3'b000);
        add(1, 0, 3'b101, 3'b101, 0, 1, 3'b100, 1, 3'b000, 3'b000);
        add(1, 1, 3'b101, 3'b101, 0, 1, 3'b000, 0, 3'b000, 3'b000);
        add(1, 1, 3'b101, 3'b101, 0, 1, 3'b001, 1, 3'b000, 3'b000);
        add(1, 1, 3'b000, 3'b000, 0, 1, 3'b001, 0, 3'b000, 3'b000);
        add(1, 1, 3'b000, 3'b000, 0, 1, 3'b000, 0, 3'b000, 3'b000);

        rst_i   = 1'b0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
        @(posedge clk);
        #1;

        foreach (tbl[r]) begin
            tick(tbl[r].rstn, tbl[r].cyc, tbl[r].stb, tbl[r].sack, 1'b0);
            if (tbl[r].en) begin
                chk($sformatf("row%0d_gnt", r),   32'(cap_gnt), 32'(tbl[r].gnt));
                chk($sformatf("row%0d_s_cyc", r), 32'(cap_cyc), 32'(tbl[r].scyc));
                chk($sformatf("row%0d_ack", r),   32'(cap_ack), 32'(tbl[r].ack));
                chk($sformatf("row%0d_err", r),   32'(cap_err), 32'(tbl[r].err));
            end
        end

        begin
            logic [N-1:0] rc;
            rc = '0;
            for (int c = 0; c < 600; c++) begin
                for (int m = 0; m < N; m++) begin
                    if ($urandom_range(0, 5) == 0) rc[m] = ~rc[m];
                end
                tick(($urandom_range(0, 99) != 0), rc, N'($urandom),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
